lcd_refresh_scheduler: RTL and testbench



---
 rtl/lcd_refresh_scheduler_if.sv | 35 +++
 rtl/lcd_refresh_scheduler.sv | 151 +++++++++++++++
 tb/tb_lcd_refresh_scheduler.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_refresh_scheduler_if.sv
// -----------------------------------------------------------------------------
// lcd_refresh_scheduler_if
// Bundles the host write port and the lcd_controller write port of the
// LCD refresh scheduler.
//   wr_en / wr_addr / wr_data : single-cycle host writes into the shadow buffer
//   clear                     : one-cycle request to blank the whole buffer
//   lcd_ready                 : ready from lcd_controller
//   lcd_char_data / lcd_cursor_pos / lcd_write_enable : to lcd_controller
//   busy / all_clean          : scheduler status
// Modports:
//   master : environment side (host + lcd_controller ready)
//   slave  : the scheduler itself
// -----------------------------------------------------------------------------
interface lcd_refresh_scheduler_if;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       clear;
    logic       lcd_ready;
    logic [7:0] lcd_char_data;
    logic [4:0] lcd_cursor_pos;
    logic       lcd_write_enable;
    logic       busy;
    logic       all_clean;

    modport master (
        output wr_en, wr_addr, wr_data, clear, lcd_ready,
        input  lcd_char_data, lcd_cursor_pos, lcd_write_enable, busy, all_clean
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, clear, lcd_ready,
        output lcd_char_data, lcd_cursor_pos, lcd_write_enable, busy, all_clean
    );
endinterface

// File: rtl/lcd_refresh_scheduler.sv
// -----------------------------------------------------------------------------
// lcd_refresh_scheduler
// Owns a 2x16 character shadow buffer (index 0-15 line 1, 16-31 line 2) and
// pushes changed cells to lcd_controller one at a time, hiding all LCD timing
// from the application.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset (buffer blanked, all cells dirty)
//   bus   : lcd_refresh_scheduler_if.slave (host write port, lcd port, status)
// Parameters:
//   SETUP_CYCLES : cycles cursor/data are held before the write pulse
//   HOLD_CYCLES  : cycles after the pulse before lcd_ready is looked at again
//   CNT_W        : delay counter width, must hold max(SETUP_CYCLES, HOLD_CYCLES)
// -----------------------------------------------------------------------------
module lcd_refresh_scheduler #(
    parameter int SETUP_CYCLES = 16,
    parameter int HOLD_CYCLES  = 4,
    parameter int CNT_W        = 20
) (
    input  logic                    clk,
    input  logic                    rst_n,
    lcd_refresh_scheduler_if.slave  bus
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SCAN     = 3'd1;
    localparam logic [2:0] ST_SETUP    = 3'd2;
    localparam logic [2:0] ST_HOLD     = 3'd3;
    localparam logic [2:0] ST_WAIT_RDY = 3'd4;

    localparam logic [7:0] SPACE = 8'h20;

    logic [7:0]       buffer_reg [32];
    logic [31:0]      dirty_reg;
    logic [31:0]      dirty_next;
    logic [2:0]       state_reg;
    logic [4:0]       scan_ptr_reg;
    logic [CNT_W-1:0] counter_reg;
    logic [7:0]       char_reg;
    logic [4:0]       pos_reg;
    logic             we_reg;
    logic             svc_take;

    // Scheduler picks up the cell under scan_ptr this cycle.
    assign svc_take = (state_reg == ST_SCAN) && dirty_reg[scan_ptr_reg];

    // Shadow buffer: clear has priority over a host write.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_cell
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    buffer_reg[gi] <= SPACE;
                end else if (bus.clear) begin
                    buffer_reg[gi] <= SPACE;
                end else if (bus.wr_en && (bus.wr_addr == 5'(gi))) begin
                    buffer_reg[gi] <= bus.wr_data;
                end
            end
        end
    endgenerate

    // Host set is applied after the scheduler clear, so a write landing in the
    // same cycle the cell is taken keeps it dirty and it gets re-sent.
    always_comb begin
        dirty_next = dirty_reg;
        if (svc_take) begin
            dirty_next[scan_ptr_reg] = 1'b0;
        end
        if (bus.clear) begin
            dirty_next = '1;
        end else if (bus.wr_en) begin
            dirty_next[bus.wr_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dirty_reg <= '1;
        end else begin
            dirty_reg <= dirty_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            scan_ptr_reg <= '0;
            counter_reg  <= '0;
            char_reg     <= SPACE;
            pos_reg      <= '0;
            we_reg       <= 1'b0;
        end else begin
            we_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (dirty_reg != '0) begin
                        state_reg <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (dirty_reg[scan_ptr_reg]) begin
                        char_reg    <= buffer_reg[scan_ptr_reg];
                        pos_reg     <= scan_ptr_reg;
                        counter_reg <= CNT_W'(SETUP_CYCLES);
                        state_reg   <= ST_SETUP;
                    end else begin
                        // 5-bit pointer wraps 31 -> 0 on its own.
                        scan_ptr_reg <= scan_ptr_reg + 5'd1;
                        if (dirty_reg == '0) begin
                            state_reg <= ST_IDLE;
                        end
                    end
                end
                ST_SETUP: begin
                    if (counter_reg != '0) begin
                        counter_reg <= counter_reg - 1'b1;
                    end else if (bus.lcd_ready) begin
                        // Pulse is registered: high for the first HOLD cycle only.
                        we_reg      <= 1'b1;
                        counter_reg <= CNT_W'(HOLD_CYCLES);
                        state_reg   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (counter_reg != '0) begin
                        counter_reg <= counter_reg - 1'b1;
                    end else begin
                        state_reg <= ST_WAIT_RDY;
                    end
                end
                ST_WAIT_RDY: begin
                    if (bus.lcd_ready) begin
                        // Resume one past the serviced cell: round-robin, no starvation.
                        scan_ptr_reg <= scan_ptr_reg + 5'd1;
                        state_reg    <= (dirty_reg != '0) ? ST_SCAN : ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.lcd_char_data    = char_reg;
    assign bus.lcd_cursor_pos   = pos_reg;
    assign bus.lcd_write_enable = we_reg;
    assign bus.busy             = (state_reg != ST_IDLE);
    assign bus.all_clean        = (dirty_reg == '0) && (state_reg == ST_IDLE);

endmodule

// File: tb/tb_lcd_refresh_scheduler.sv
// -----------------------------------------------------------------------------
// tb_lcd_refresh_scheduler
// Directed bench for lcd_refresh_scheduler. A monitor logs every write pulse
// (one line per pulse) into queues; the directed sequence compares them with
// hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_lcd_refresh_scheduler;

    logic clk;
    logic rst_n;

    lcd_refresh_scheduler_if bus ();

    lcd_refresh_scheduler #(
        .SETUP_CYCLES (16),
        .HOLD_CYCLES  (4),
        .CNT_W        (20)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic prev_we = 1'b0;

    logic [4:0] pulse_pos  [$];
    logic [7:0] pulse_data [$];
    int         pulse_cyc  [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Pulse monitor: record each pulse and confirm it is never back-to-back.
    always @(negedge clk) begin
        if (rst_n && bus.lcd_write_enable) begin
            check("we_single_cycle", {31'd0, prev_we}, 32'd0);
            pulse_pos.push_back(bus.lcd_cursor_pos);
            pulse_data.push_back(bus.lcd_char_data);
            pulse_cyc.push_back(cyc);
            $display("pulse pos=%0d data=0x%02h cyc=%0d", bus.lcd_cursor_pos, bus.lcd_char_data, cyc);
        end
        prev_we = rst_n ? bus.lcd_write_enable : 1'b0;
    end

    task automatic clear_log();
        pulse_pos.delete();
        pulse_data.delete();
        pulse_cyc.delete();
    endtask

    // Called at a negedge; drives one host write for one cycle.
    task automatic host_write(input logic [4:0] a, input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic wait_pulses(input int n, input string tag);
        for (int k = 0; k < 4000 && pulse_pos.size() < n; k++) @(negedge clk);
        check(tag, pulse_pos.size(), n);
    endtask

    task automatic wait_clean(input string tag);
        for (int k = 0; k < 300 && !bus.all_clean; k++) @(negedge clk);
        check({tag, "_all_clean"}, {31'd0, bus.all_clean}, 32'd1);
        check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic check_full_blank(input string tag);
        wait_pulses(32, {tag, "_count"});
        for (int i = 0; i < 32 && i < pulse_pos.size(); i++) begin
            check($sformatf("%s_pos%0d", tag, i), {27'd0, pulse_pos[i]}, i);
            check($sformatf("%s_data%0d", tag, i), {24'd0, pulse_data[i]}, 32'h20);
        end
        wait_clean(tag);
        check({tag, "_no_extra"}, pulse_pos.size(), 32);
    endtask

    initial begin
        int bad;
        int seen;
        logic [31:0] mask;

        rst_n         = 1'b0;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.clear     = 1'b0;
        bus.lcd_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_we",        {31'd0, bus.lcd_write_enable}, 32'd0);
        check("rst_char",      {24'd0, bus.lcd_char_data},    32'h20);
        check("rst_pos",       {27'd0, bus.lcd_cursor_pos},   32'd0);
        check("rst_busy",      {31'd0, bus.busy},             32'd0);
        check("rst_all_clean", {31'd0, bus.all_clean},        32'd0);

        // 1: power-up blank refresh, 0..31 in order
        rst_n = 1'b1;
        check_full_blank("t1");

        // 2: two cells, in index order, with minimum spacing
        clear_log();
        host_write(5'd3, 8'h48);
        host_write(5'd17, 8'h46);
        wait_pulses(2, "t2_count");
        if (pulse_pos.size() >= 2) begin
            check("t2_pos0",  {27'd0, pulse_pos[0]},  32'd3);
            check("t2_data0", {24'd0, pulse_data[0]}, 32'h48);
            check("t2_pos1",  {27'd0, pulse_pos[1]},  32'd17);
            check("t2_data1", {24'd0, pulse_data[1]}, 32'h46);
            check("t2_spacing", {31'd0, (pulse_cyc[1] - pulse_cyc[0]) >= 23}, 32'd1);
        end
        wait_clean("t2");
        check("t2_no_extra", pulse_pos.size(), 2);

        // 3: lcd_ready low holds off the pulse; pulse one cycle after it rises
        clear_log();
        bus.lcd_ready = 1'b0;
        host_write(5'd8, 8'h55);
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus.lcd_write_enable) bad++;
        end
        repeat (200) begin
            @(negedge clk);
            if (bus.lcd_write_enable || bus.lcd_cursor_pos != 5'd8 || bus.lcd_char_data != 8'h55) bad++;
        end
        check("t3_stall_stable", bad, 0);
        check("t3_busy_stalled", {31'd0, bus.busy}, 32'd1);
        bus.lcd_ready = 1'b1;
        @(negedge clk);
        check("t3_pulse_after_ready", {31'd0, bus.lcd_write_enable}, 32'd1);
        wait_clean("t3");
        check("t3_count", pulse_pos.size(), 1);
        if (pulse_pos.size() >= 1) begin
            check("t3_pos",  {27'd0, pulse_pos[0]},  32'd8);
            check("t3_data", {24'd0, pulse_data[0]}, 32'h55);
        end

        // 4: rewrite of a cell in the cycle its dirty bit is taken
        clear_log();
        host_write(5'd4, 8'h34);
        host_write(5'd5, 8'h41);
        seen = 0;
        for (int k = 0; k < 2000 && seen == 0; k++) begin
            @(negedge clk);
            if (bus.lcd_write_enable) seen = 1;
        end
        check("t4_first_pulse_seen", seen, 1);
        bus.lcd_ready = 1'b0;          // park the scheduler in WAIT_RDY after pos 4
        repeat (20) @(negedge clk);
        bus.lcd_ready = 1'b1;          // next edge: WAIT_RDY -> SCAN at pos 5
        @(negedge clk);
        host_write(5'd5, 8'h42);       // lands on the edge that takes cell 5
        wait_pulses(3, "t4_count");
        if (pulse_pos.size() >= 3) begin
            check("t4_pos0",  {27'd0, pulse_pos[0]},  32'd4);
            check("t4_data0", {24'd0, pulse_data[0]}, 32'h34);
            check("t4_pos1",  {27'd0, pulse_pos[1]},  32'd5);
            check("t4_data1", {24'd0, pulse_data[1]}, 32'h41);
            check("t4_pos2",  {27'd0, pulse_pos[2]},  32'd5);
            check("t4_data2", {24'd0, pulse_data[2]}, 32'h42);
        end
        wait_clean("t4");
        check("t4_no_extra", pulse_pos.size(), 3);

        // 5: clear wins over a same-cycle write
        clear_log();
        bus.clear   = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'd0;
        bus.wr_data = 8'h58;
        @(negedge clk);
        bus.clear   = 1'b0;
        bus.wr_en   = 1'b0;
        wait_pulses(32, "t5_count");
        mask = '0;
        bad  = 0;
        for (int i = 0; i < pulse_pos.size(); i++) begin
            mask[pulse_pos[i]] = 1'b1;
            if (pulse_data[i] != 8'h20) bad++;
        end
        check("t5_all_cells", mask, 32'hFFFF_FFFF);
        check("t5_all_space", bad, 0);
        wait_clean("t5");
        check("t5_no_extra", pulse_pos.size(), 32);

        // 6: reset during HOLD
        host_write(5'd10, 8'h77);
        seen = 0;
        for (int k = 0; k < 2000 && seen == 0; k++) begin
            @(negedge clk);
            if (bus.lcd_write_enable) seen = 1;
        end
        check("t6_pulse_seen", seen, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_we",   {31'd0, bus.lcd_write_enable}, 32'd0);
        check("t6_async_char", {24'd0, bus.lcd_char_data},    32'h20);
        check("t6_async_pos",  {27'd0, bus.lcd_cursor_pos},   32'd0);
        check("t6_async_busy", {31'd0, bus.busy},             32'd0);
        clear_log();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_full_blank("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
